// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI burst memory.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    // Only FIXED and INCR are served; 10/11 produce SLVERR on every beat
    function automatic logic burst_ok(input logic [1:0] b);
        return (b == 2'(BURST_FIXED)) || (b == 2'(BURST_INCR));
    endfunction

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Per-channel beat address stepping. The address carries one extra bit so
// that stepping past the last word saturates out of range instead of wrapping.
module axi_mem_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 64
) (
    input  logic [ADDR_WIDTH:0] cur,
    input  logic [1:0]          burst,
    output logic [ADDR_WIDTH:0] next,
    output logic                in_range
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    // Out-of-range addresses are held so the rest of the burst stays in error
    always_comb begin
        in_range = (cur < DEPTH);
        next     = cur;
        if (burst == 2'(BURST_INCR) && in_range)
            next = cur + 1'b1;
    end

endmodule

// File: rtl/axi_burst_memory.sv
// Word-addressed AXI4 slave RAM with independent write and read channels,
// FIXED/INCR bursts, byte strobes and SLVERR on out-of-range/unsupported beats.
module axi_burst_memory
    import axi_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 64,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [LEN_WIDTH-1:0]    AWLEN,
    input  logic [1:0]              AWBURST,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [LEN_WIDTH-1:0]    ARLEN,
    input  logic [1:0]              ARBURST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    wstate_t               wstate;
    logic [ADDR_WIDTH:0]   waddr, w_next;
    logic [LEN_WIDTH-1:0]  wlen;
    logic [1:0]            wburst;
    logic [LEN_WIDTH:0]    wcnt;
    logic                  werr;
    logic                  w_in_range, w_ok, w_last, w_beat_err, mem_we;

    axi_mem_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_wgen (
        .cur      (waddr),
        .burst    (wburst),
        .next     (w_next),
        .in_range (w_in_range)
    );

    // Per-beat write qualification: data is stored even when only WLAST is wrong
    always_comb begin
        w_ok       = w_in_range && burst_ok(wburst);
        w_last     = (wcnt == {1'b0, wlen});
        w_beat_err = !w_ok || (WLAST != w_last);
        mem_we     = (wstate == W_DATA) && WVALID && WREADY && w_ok;
    end

    // Write FSM: AW latch, beat counting, error accumulation, B response
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate  <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            waddr   <= '0;
            wlen    <= '0;
            wburst  <= '0;
            wcnt    <= '0;
            werr    <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (!AWREADY) begin
                        AWREADY <= 1'b1;
                    end else if (AWVALID) begin
                        waddr   <= {1'b0, AWADDR};
                        wlen    <= AWLEN;
                        wburst  <= AWBURST;
                        wcnt    <= '0;
                        werr    <= 1'b0;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WVALID) begin
                        werr  <= werr | w_beat_err;
                        waddr <= w_next;
                        wcnt  <= wcnt + 1'b1;
                        if (w_last) begin
                            WREADY <= 1'b0;
                            BVALID <= 1'b1;
                            BRESP  <= (werr | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        BRESP   <= RESP_OKAY;
                        AWREADY <= 1'b1;
                        wstate  <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Storage: byte-strobed writes, no reset so contents survive ARESET
    always_ff @(posedge ACLK) begin
        for (int b = 0; b < NB; b++)
            if (mem_we && WSTRB[b])
                mem[waddr[IDX_W-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
    end

    // ---------------- read channel ----------------
    rstate_t               rstate;
    logic [ADDR_WIDTH:0]   raddr, r_cur, r_next;
    logic [LEN_WIDTH-1:0]  rlen;
    logic [1:0]            rburst, r_burst;
    logic [LEN_WIDTH:0]    rcnt;
    logic                  r_in_range, r_ok;
    logic [DATA_WIDTH-1:0] r_word;

    // raddr is the address of the next beat to load; in idle the AR bus is used directly
    always_comb begin
        r_cur   = (rstate == R_IDLE) ? {1'b0, ARADDR} : raddr;
        r_burst = (rstate == R_IDLE) ? ARBURST : rburst;
        r_ok    = r_in_range && burst_ok(r_burst);
        r_word  = r_ok ? mem[r_cur[IDX_W-1:0]] : '0;
    end

    axi_mem_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_rgen (
        .cur      (r_cur),
        .burst    (r_burst),
        .next     (r_next),
        .in_range (r_in_range)
    );

    // Read FSM: beat 0 loads on the AR edge, then one beat per R handshake
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate  <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            RLAST   <= 1'b0;
            raddr   <= '0;
            rlen    <= '0;
            rburst  <= '0;
            rcnt    <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (!ARREADY) begin
                        ARREADY <= 1'b1;
                    end else if (ARVALID) begin
                        rlen    <= ARLEN;
                        rburst  <= ARBURST;
                        raddr   <= r_next;
                        rcnt    <= '0;
                        RVALID  <= 1'b1;
                        RDATA   <= r_word;
                        RRESP   <= r_ok ? RESP_OKAY : RESP_SLVERR;
                        RLAST   <= (ARLEN == '0);
                        ARREADY <= 1'b0;
                        rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            RDATA   <= '0;
                            RRESP   <= RESP_OKAY;
                            ARREADY <= 1'b1;
                            rstate  <= R_IDLE;
                        end else begin
                            RDATA <= r_word;
                            RRESP <= r_ok ? RESP_OKAY : RESP_SLVERR;
                            raddr <= r_next;
                            rcnt  <= rcnt + 1'b1;
                            RLAST <= ((rcnt + 1'b1) == {1'b0, rlen});
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_memory.sv
// Scoreboard bench: stimulus tasks queue expected B/R responses, a negedge
// monitor compares whatever the DUT presents against the queue heads.
module tb_axi_burst_memory;
    import axi_mem_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        AWVALID = 0, AWREADY;
    logic [7:0]  AWADDR = 0, AWLEN = 0;
    logic [1:0]  AWBURST = 0;
    logic        WVALID = 0, WREADY;
    logic [31:0] WDATA = 0;
    logic [3:0]  WSTRB = 0;
    logic        WLAST = 0;
    logic        BVALID, BREADY = 1;
    logic [1:0]  BRESP;
    logic        ARVALID = 0, ARREADY;
    logic [7:0]  ARADDR = 0, ARLEN = 0;
    logic [1:0]  ARBURST = 0;
    logic        RVALID, RREADY = 1;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;

    axi_burst_memory dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } rexp_t;

    rexp_t      rq[$];
    logic [1:0] bq[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [31:0] wd [4];
    logic [31:0] ed [4];
    logic [1:0]  er [4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare presented beats every cycle (covers stall stability), pop on handshake
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (RVALID) begin
                n_chk++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL r_unexpected: got data %h resp %b last %b", RDATA, RRESP, RLAST);
                end else begin
                    if ({RDATA, RRESP, RLAST} !== rq[0]) begin
                        n_fail++;
                        $display("FAIL r_beat: got %h/%b/%b expected %h/%b/%b",
                                 RDATA, RRESP, RLAST, rq[0].d, rq[0].r, rq[0].l);
                    end
                    if (RREADY) void'(rq.pop_front());
                end
            end
            if (BVALID) begin
                n_chk++;
                if (bq.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_unexpected: got bresp %b", BRESP);
                end else begin
                    if (BRESP !== bq[0]) begin
                        n_fail++;
                        $display("FAIL b_resp: got %b expected %b", BRESP, bq[0]);
                    end
                    if (BREADY) void'(bq.pop_front());
                end
            end
        end
    end

    // Wait (bounded) for a ready/valid seen at negedge, then step past the handshake edge
    task automatic wait_sig(input int sel, input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ACLK);
            case (sel)
                0: ok = AWREADY;
                1: ok = WREADY;
                2: ok = ARREADY;
                default: ok = BVALID;
            endcase
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL timeout_%s: got 0 expected 1", nm);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] len, input logic [1:0] bu,
                            input logic [3:0] strb, input logic [3:0] lmask, input logic [1:0] eb);
        bq.push_back(eb);
        AWVALID = 1; AWADDR = a; AWLEN = len; AWBURST = bu;
        wait_sig(0, "aw");
        AWVALID = 0;
        for (int b = 0; b <= int'(len); b++) begin
            WVALID = 1; WDATA = wd[b]; WSTRB = strb; WLAST = lmask[b];
            wait_sig(1, "w");
        end
        WVALID = 0; WLAST = 0;
        wait_sig(3, "b");
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] len, input logic [1:0] bu,
                           input logic toggle);
        rexp_t e;
        for (int b = 0; b <= int'(len); b++) begin
            e.d = ed[b]; e.r = er[b]; e.l = (b == int'(len));
            rq.push_back(e);
        end
        ARVALID = 1; ARADDR = a; ARLEN = len; ARBURST = bu;
        RREADY = !toggle;
        wait_sig(2, "ar");
        ARVALID = 0;
        for (int i = 0; i < 100 && rq.size() != 0; i++) begin
            if (toggle) RREADY = !RREADY;
            @(posedge ACLK); #1;
        end
        check("r_drain", 64'(rq.size()), 64'd0);
        RREADY = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge ACLK);
        check("reset_outs", {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BRESP, RRESP},
              64'd0);
        @(posedge ACLK); #1 ARESET = 0;
        @(posedge ACLK); #1;
        check("ready_after_reset", {AWREADY, ARREADY}, 64'b11);

        // Single beat write/read
        wd = '{32'hDEADBEEF, 0, 0, 0};
        do_write(8'd3, 8'd0, 2'b01, 4'hF, 4'b0001, RESP_OKAY);
        ed = '{32'hDEADBEEF, 0, 0, 0}; er = '{RESP_OKAY, 0, 0, 0};
        do_read(8'd3, 8'd0, 2'b01, 1'b0);

        // INCR 4 beats, read back with RREADY toggling
        wd = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write(8'd10, 8'd3, 2'b01, 4'hF, 4'b1000, RESP_OKAY);
        ed = '{32'd1, 32'd2, 32'd3, 32'd4}; er = '{RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY};
        do_read(8'd10, 8'd3, 2'b01, 1'b1);

        // FIXED burst lands all beats on word 5
        wd = '{32'h66666666, 0, 0, 0};
        do_write(8'd6, 8'd0, 2'b01, 4'hF, 4'b0001, RESP_OKAY);
        wd = '{32'hA, 32'hB, 32'hC, 0};
        do_write(8'd5, 8'd2, 2'b00, 4'hF, 4'b0100, RESP_OKAY);
        ed = '{32'hC, 32'h66666666, 0, 0}; er = '{RESP_OKAY, RESP_OKAY, 0, 0};
        do_read(8'd5, 8'd1, 2'b01, 1'b0);

        // Byte strobe
        wd = '{32'h0, 0, 0, 0};
        do_write(8'd0, 8'd0, 2'b01, 4'hF, 4'b0001, RESP_OKAY);
        wd = '{32'hFFFFFFFF, 0, 0, 0};
        do_write(8'd0, 8'd0, 2'b01, 4'b0010, 4'b0001, RESP_OKAY);
        ed = '{32'h0000FF00, 0, 0, 0}; er = '{RESP_OKAY, 0, 0, 0};
        do_read(8'd0, 8'd0, 2'b01, 1'b0);

        // Running off the end of memory
        wd = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write(8'd62, 8'd3, 2'b01, 4'hF, 4'b1000, RESP_SLVERR);
        ed = '{32'd1, 32'd2, 32'd0, 32'd0}; er = '{RESP_OKAY, RESP_OKAY, RESP_SLVERR, RESP_SLVERR};
        do_read(8'd62, 8'd3, 2'b01, 1'b0);

        // WLAST early (beat 2 of 4) and missing on the final beat
        wd = '{32'd5, 32'd6, 32'd7, 32'd8};
        do_write(8'd30, 8'd3, 2'b01, 4'hF, 4'b0010, RESP_SLVERR);
        ed = '{32'd5, 32'd6, 32'd7, 32'd8}; er = '{RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_OKAY};
        do_read(8'd30, 8'd3, 2'b01, 1'b0);

        // Unsupported burst type on both channels
        wd = '{32'h40, 32'h41, 0, 0};
        do_write(8'd40, 8'd1, 2'b01, 4'hF, 4'b0010, RESP_OKAY);
        wd = '{32'h99, 32'h98, 0, 0};
        do_write(8'd40, 8'd1, 2'b10, 4'hF, 4'b0010, RESP_SLVERR);
        ed = '{32'h40, 32'h41, 0, 0}; er = '{RESP_OKAY, RESP_OKAY, 0, 0};
        do_read(8'd40, 8'd1, 2'b01, 1'b0);
        ed = '{32'h0, 32'h0, 0, 0}; er = '{RESP_SLVERR, RESP_SLVERR, 0, 0};
        do_read(8'd40, 8'd1, 2'b10, 1'b0);

        // Same-edge read and write of word 0: read sees old data
        AWVALID = 1; AWADDR = 8'd0; AWLEN = 8'd0; AWBURST = 2'b01;
        wait_sig(0, "aw_conc");
        AWVALID = 0;
        rq.push_back('{d: 32'h0000FF00, r: RESP_OKAY, l: 1'b1});
        bq.push_back(RESP_OKAY);
        WVALID = 1; WDATA = 32'h12345678; WSTRB = 4'hF; WLAST = 1;
        ARVALID = 1; ARADDR = 8'd0; ARLEN = 8'd0; ARBURST = 2'b01; RREADY = 1;
        @(negedge ACLK);
        check("conc_ready", {WREADY, ARREADY}, 64'b11);
        @(posedge ACLK); #1;
        WVALID = 0; WLAST = 0; ARVALID = 0;
        repeat (4) @(posedge ACLK);
        #1;
        check("conc_drain", 64'(rq.size() + bq.size()), 64'd0);
        ed = '{32'h12345678, 0, 0, 0}; er = '{RESP_OKAY, 0, 0, 0};
        do_read(8'd0, 8'd0, 2'b01, 1'b0);

        // Reset in the middle of a write burst
        AWVALID = 1; AWADDR = 8'd20; AWLEN = 8'd3; AWBURST = 2'b01;
        wait_sig(0, "aw_rst");
        AWVALID = 0;
        WVALID = 1; WDATA = 32'hAA; WSTRB = 4'hF; WLAST = 0;
        wait_sig(1, "w_rst");
        WVALID = 0;
        ARESET = 1;
        @(negedge ACLK);
        check("rst_mid_outs", {BVALID, WREADY, AWREADY}, 64'b000);
        @(posedge ACLK); #1 ARESET = 0;
        @(negedge ACLK);
        check("rst_awready_low", {AWREADY, BVALID}, 64'b00);
        @(posedge ACLK); #1;
        check("rst_awready_high", {AWREADY, BVALID}, 64'b10);
        ed = '{32'hAA, 0, 0, 0}; er = '{RESP_OKAY, 0, 0, 0};
        do_read(8'd20, 8'd0, 2'b01, 1'b0);

        repeat (3) @(posedge ACLK);
        #1;
        check("final_queues", 64'(rq.size() + bq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
